// File: rtl/nv_nvdla_csb_pkg.sv
// Shared CSB definitions: packet widths, request/response field positions,
// source ids for the two CSB masters, and the "needs a response" decode.
package nv_nvdla_csb_pkg;

  localparam int REQ_PD_W        = 63;
  localparam int RESP_PD_W       = 34;
  localparam int CSB_WRITE_BIT   = 54;
  localparam int CSB_NPOSTED_BIT = 55;
  localparam int RESP_PKTID_BIT  = 33;

  typedef enum logic {
    SRC_A = 1'b0,
    SRC_B = 1'b1
  } csb_src_e;

  // Reads always return data; writes return an ack only when non-posted.
  function automatic logic csb_needs_resp(input logic write, input logic nposted);
    return !write || nposted;
  endfunction

endpackage

// File: rtl/nv_nvdla_csb_arb_tagfifo.sv
// In-order source-id FIFO for outstanding non-posted CSB requests.
// Ports:
//   nvdla_core_clk / nvdla_core_rstn : clock, async active-low reset
//   push / push_src                  : enqueue the granted source id
//   pop                              : dequeue head (ignored when empty)
//   head_src                         : source id at the head
//   count / full / empty             : occupancy
module nv_nvdla_csb_arb_tagfifo #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 4
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rstn,
  input  logic             push,
  input  logic             push_src,
  input  logic             pop,
  output logic             head_src,
  output logic [CNT_W-1:0] count,
  output logic             full,
  output logic             empty
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [DEPTH-1:0] mem;
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full     = (count == CNT_W'(DEPTH));
  assign empty    = (count == '0);
  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign head_src = mem[rd_ptr];

  // DEPTH is a power of two, so the pointers wrap naturally.
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      mem    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= push_src;
        wr_ptr      <= wr_ptr + 1'b1;
      end
      if (do_pop) rd_ptr <= rd_ptr + 1'b1;
      if (do_push && !do_pop)      count <= count + 1'b1;
      else if (do_pop && !do_push) count <= count - 1'b1;
    end
  end

endmodule

// File: rtl/nv_nvdla_csb_cacc_arb.sv
// Round-robin arbiter sharing the CSB->CACC request channel between master A
// (main CSB) and master B (debug CSB). Non-posted requests are tagged in order
// so each CACC response is routed back to its issuer.
// Ports:
//   nvdla_core_clk / nvdla_core_rstn   : clock, async active-low reset
//   csb_{a,b}_req_pvld/prdy/pd         : requester request channels
//   csb_{a,b}_resp_valid/pd            : per-requester responses (no backpressure)
//   cacc_req_pvld/prdy/pd              : registered request to the target
//   cacc_resp_valid/pd                 : response from the target
//   arb_ost_cnt                        : outstanding non-posted count
//   arb_resp_err                       : sticky unexpected-response / timeout flag
// Optional: define NVDLA_CSB_ARB_TIMEOUT_EN to synthesize a response after
// TMO_CYC cycles without one.
module nv_nvdla_csb_cacc_arb
  import nv_nvdla_csb_pkg::*;
#(
  parameter int OST_DEPTH = 8,
  parameter int CNT_W     = 4,
  parameter int TMO_CYC   = 1023
) (
  input  logic                 nvdla_core_clk,
  input  logic                 nvdla_core_rstn,
  input  logic                 csb_a_req_pvld,
  output logic                 csb_a_req_prdy,
  input  logic [REQ_PD_W-1:0]  csb_a_req_pd,
  output logic                 csb_a_resp_valid,
  output logic [RESP_PD_W-1:0] csb_a_resp_pd,
  input  logic                 csb_b_req_pvld,
  output logic                 csb_b_req_prdy,
  input  logic [REQ_PD_W-1:0]  csb_b_req_pd,
  output logic                 csb_b_resp_valid,
  output logic [RESP_PD_W-1:0] csb_b_resp_pd,
  output logic                 cacc_req_pvld,
  input  logic                 cacc_req_prdy,
  output logic [REQ_PD_W-1:0]  cacc_req_pd,
  input  logic                 cacc_resp_valid,
  input  logic [RESP_PD_W-1:0] cacc_resp_pd,
  output logic [CNT_W-1:0]     arb_ost_cnt,
  output logic                 arb_resp_err
);

  if (CNT_W != $clog2(OST_DEPTH) + 1 || TMO_CYC < 1) begin : g_param_chk
    $error("nv_nvdla_csb_cacc_arb: inconsistent OST_DEPTH/CNT_W/TMO_CYC");
  end

  csb_src_e       rr_ptr;
  logic           a_need, b_need;
  logic           elig_a, elig_b;
  logic           load_ok;
  logic           gnt_a, gnt_b;
  logic           push;
  logic           resp_pop, tmo_pop, pop;
  logic           resp_unexp;
  logic           tag_head, tag_full, tag_empty;
  logic [RESP_PD_W-1:0] resp_pd_sel;

  // ---------------- arbitration ----------------
  assign a_need  = csb_needs_resp(csb_a_req_pd[CSB_WRITE_BIT], csb_a_req_pd[CSB_NPOSTED_BIT]);
  assign b_need  = csb_needs_resp(csb_b_req_pd[CSB_WRITE_BIT], csb_b_req_pd[CSB_NPOSTED_BIT]);
  // Full is judged on the registered count, so a same-cycle pop does not
  // open a slot until the next cycle. Posted writes never need a slot.
  assign elig_a  = csb_a_req_pvld && (!a_need || !tag_full);
  assign elig_b  = csb_b_req_pvld && (!b_need || !tag_full);
  assign load_ok = !cacc_req_pvld || cacc_req_prdy;
  assign gnt_a   = load_ok && elig_a && (!elig_b || rr_ptr == SRC_A);
  assign gnt_b   = load_ok && elig_b && (!elig_a || rr_ptr == SRC_B);

  assign csb_a_req_prdy = gnt_a;
  assign csb_b_req_prdy = gnt_b;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      cacc_req_pvld <= 1'b0;
      cacc_req_pd   <= '0;
      rr_ptr        <= SRC_A;
    end else begin
      if (load_ok) begin
        cacc_req_pvld <= gnt_a || gnt_b;
        if (gnt_a)      cacc_req_pd <= csb_a_req_pd;
        else if (gnt_b) cacc_req_pd <= csb_b_req_pd;
      end
      // Pointer only moves on a contested grant.
      if (load_ok && elig_a && elig_b) rr_ptr <= gnt_a ? SRC_B : SRC_A;
    end
  end

  // ---------------- outstanding tags ----------------
  assign push       = (gnt_a && a_need) || (gnt_b && b_need);
  assign resp_pop   = cacc_resp_valid && !tag_empty;
  assign resp_unexp = cacc_resp_valid && tag_empty;
  assign pop        = resp_pop || tmo_pop;

  nv_nvdla_csb_arb_tagfifo #(
    .DEPTH (OST_DEPTH),
    .CNT_W (CNT_W)
  ) u_tagfifo (
    .nvdla_core_clk  (nvdla_core_clk),
    .nvdla_core_rstn (nvdla_core_rstn),
    .push            (push),
    .push_src        (gnt_b),
    .pop             (pop),
    .head_src        (tag_head),
    .count           (arb_ost_cnt),
    .full            (tag_full),
    .empty           (tag_empty)
  );

`ifdef NVDLA_CSB_ARB_TIMEOUT_EN
  localparam int TMO_W = $clog2(TMO_CYC + 1);
  logic [TMO_W-1:0] tmo_cnt;

  // A real response in the same cycle wins; the timeout only fires when
  // nothing else is popping the head.
  assign tmo_pop = (tmo_cnt == TMO_W'(TMO_CYC)) && !tag_empty && !cacc_resp_valid;

  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn)                 tmo_cnt <= '0;
    else if (pop || tag_empty)            tmo_cnt <= '0;
    else if (tmo_cnt != TMO_W'(TMO_CYC))  tmo_cnt <= tmo_cnt + 1'b1;
  end
`else
  assign tmo_pop = 1'b0;
`endif

  // Synthesized timeout response is all-zero (pkt id 0, read data 0).
  assign resp_pd_sel = tmo_pop ? '0 : cacc_resp_pd;

  // ---------------- response routing ----------------
  always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
    if (!nvdla_core_rstn) begin
      csb_a_resp_valid <= 1'b0;
      csb_b_resp_valid <= 1'b0;
      csb_a_resp_pd    <= '0;
      csb_b_resp_pd    <= '0;
      arb_resp_err     <= 1'b0;
    end else begin
      csb_a_resp_valid <= pop && (tag_head == SRC_A);
      csb_b_resp_valid <= pop && (tag_head == SRC_B);
      if (pop && tag_head == SRC_A) csb_a_resp_pd <= resp_pd_sel;
      if (pop && tag_head == SRC_B) csb_b_resp_pd <= resp_pd_sel;
      if (resp_unexp || tmo_pop)    arb_resp_err  <= 1'b1;
    end
  end

endmodule
